// File: rtl/mem_dma.sv
// mem_dma: word-granular memory-to-memory copy engine, programmed through a
// responder register window and copying through a bus initiator port.
module mem_dma #(
  parameter int LEN_BITS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address_in,
  input  logic        sel_in,
  output logic [31:0] read_value_out,
  input  logic [3:0]  write_mask_in,
  input  logic [31:0] write_value_in,
  output logic        ready_out,
  output logic [31:0] address_out,
  output logic        read_out,
  output logic        write_out,
  input  logic [31:0] read_value_in,
  output logic [3:0]  write_mask_out,
  output logic [31:0] write_value_out,
  input  logic        ready_in,
  input  logic        fault_in
);
  typedef enum logic [1:0] {IDLE, RD, WR} state_t;
  state_t state_q, state_d;
  logic [31:0] src_q, src_d, dst_q, dst_d, buf_q, buf_d;
  logic [LEN_BITS-1:0] len_q, len_d;
  logic done_q, done_d, err_q, err_d;
  logic busy, reg_wr, wr_ok, start, ack, fault;
  logic [1:0] a;
  logic [31:0] lane, len_ext, rd_val;
  logic unused_addr;
  assign unused_addr = ^{address_in[31:4], address_in[1:0]};
  assign a = address_in[3:2];
  assign lane = {{8{write_mask_in[3]}}, {8{write_mask_in[2]}}, {8{write_mask_in[1]}}, {8{write_mask_in[0]}}};
  assign len_ext = 32'(len_q);
  assign busy = state_q != IDLE;
  assign reg_wr = sel_in && |write_mask_in;
  assign wr_ok = reg_wr && !busy;
  assign start = wr_ok && a == 2'd3 && write_mask_in[0] && write_value_in[0];
  assign ack = ready_in && !fault_in;
  assign fault = ready_in && fault_in;
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] m, input logic [31:0] v);
    return (old & ~m) | (v & m);
  endfunction
  always_comb begin
    state_d = state_q;
    src_d = (wr_ok && a == 2'd0) ? merge(src_q, lane, write_value_in) & ~32'h3 : src_q;
    dst_d = (wr_ok && a == 2'd1) ? merge(dst_q, lane, write_value_in) & ~32'h3 : dst_q;
    len_d = (wr_ok && a == 2'd2) ? LEN_BITS'(merge(len_ext, lane, write_value_in)) : len_q;
    buf_d = buf_q;
    done_d = done_q;
    err_d = err_q;
    unique case (state_q)
      IDLE: if (start) begin
        done_d = len_q == '0;
        err_d = 1'b0;
        state_d = len_q == '0 ? IDLE : RD;
      end
      RD: if (fault) begin
        state_d = IDLE;
        err_d = 1'b1;
        done_d = 1'b0;
      end else if (ack) begin
        buf_d = read_value_in;
        state_d = WR;
      end
      WR: if (fault) begin
        state_d = IDLE;
        err_d = 1'b1;
        done_d = 1'b0;
      end else if (ack) begin
        src_d = src_q + 32'd4;
        dst_d = dst_q + 32'd4;
        len_d = len_q - 1'b1;
        done_d = len_q == LEN_BITS'(1);
        state_d = len_q == LEN_BITS'(1) ? IDLE : RD;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      buf_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q <= src_d;
      dst_q <= dst_d;
      len_q <= len_d;
      buf_q <= buf_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  // Bus outputs decode straight from state so an async reset drops requests at once.
  assign rd_val = a == 2'd0 ? src_q : a == 2'd1 ? dst_q : a == 2'd2 ? len_ext : {29'd0, err_q, done_q, busy};
  assign read_value_out = sel_in ? rd_val : 32'd0;
  assign ready_out = sel_in;
  assign read_out = state_q == RD;
  assign write_out = state_q == WR;
  assign address_out = read_out ? src_q : write_out ? dst_q : 32'd0;
  assign write_mask_out = {4{write_out}};
  assign write_value_out = write_out ? buf_q : 32'd0;
endmodule
